vector_output_unpacker: RTL and testbench
=========================================

# vector_output_unpacker

Buffers the vector results the CPU emits from its write-back stage (the `VECTOR_SIZE*DATA_WIDTH`-bit memory read word, qualified by the output flag) and replays them one `DATA_WIDTH`-bit element at a time to a downstream sink, such as an image writer or a host link. The block sits on the consumer side of the CPU `out`/`outFlag` pair. It provides a vector FIFO to absorb bursts, a serializer with a valid/ready handshake, and overflow reporting, because the CPU has no stall input from this path.

## Interface
- `DATA_WIDTH`, 19, width of one vector element.
- `VECTOR_SIZE`, 6, elements per vector.
- `FIFO_DEPTH`, 4, number of vectors buffered; must be a power of 2 and at least 2.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `vectorIn` input `VECTOR_SIZE*DATA_WIDTH`: the CPU output vector; element k is bits `[DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]`.
- `vectorValid` input 1: the CPU output flag; `vectorIn` is captured on every edge where this is high.
- `elementOut` output `DATA_WIDTH`: current element.
- `elementValid` output 1: `elementOut`, `elementIndex` and `lastElement` are valid.
- `elementReady` input 1: the sink accepts the element on an edge where `elementValid && elementReady`.
- `elementIndex` output `$clog2(VECTOR_SIZE)`: index k of `elementOut` within its vector.
- `lastElement` output 1: high when `elementIndex == VECTOR_SIZE-1` and `elementValid` is high.
- `fifoCount` output `$clog2(FIFO_DEPTH+1)`: number of vectors stored in the FIFO, excluding the vector in the serializer.
- `almostFull` output 1: `fifoCount >= FIFO_DEPTH-1`.
- `overflow` output 1: sticky; set when a vector is dropped.

## Operation
- **Reset.** All outputs are 0, the FIFO is empty, the read and write pointers are 0, and the serializer is in IDLE.
- **FIFO write.** On an edge with `vectorValid=1`:
  - If `fifoCount < FIFO_DEPTH`, `vectorIn` is stored at the write pointer and the write pointer advances modulo `FIFO_DEPTH`.
  - Otherwise the vector is dropped and `overflow` is set to 1.
- **Full check uses the registered count.** A write while the FIFO is full is dropped even if a pop happens on the same edge.
- **Overflow clearing.** `overflow` clears only on reset.
- **Serializer state IDLE.**
  - `elementValid=0`.
  - If `fifoCount > 0`, the head vector is popped into a holding register, `elementIndex` is set to 0, and the state moves to SEND.
- **Serializer state SEND.**
  - `elementValid=1` and `elementOut` = element `elementIndex` of the holding register.
  - On handshake with `elementIndex < VECTOR_SIZE-1`: `elementIndex` increments.
  - On handshake of the last element with FIFO non-empty: the next vector is popped on the same edge and `elementIndex` is set to 0. The state stays SEND, so there are no bubble cycles between vectors.
  - On handshake of the last element with FIFO empty: the state returns to IDLE and `elementValid` drops.
- **Counter update.** `fifoCount` changes by +1 for a write, −1 for a pop, and 0 when both happen on the same edge.
- **Output stability.** While `elementValid=1 && elementReady=0`, the outputs `elementOut`, `elementIndex` and `lastElement` hold stable.
- **Vector integrity.** Elements are never reordered or skipped within a vector. A vector is either delivered whole or dropped whole.

## Timing
- **Latency.** `vectorValid` is sampled at edge t. With an empty FIFO and IDLE, `elementValid` is high after edge t+1 with element 0.
- **Throughput.** One element per cycle with `elementReady` held high, i.e. `VECTOR_SIZE` cycles per vector.
- **Capacity.** Total storage is `FIFO_DEPTH` vectors plus 1 in the serializer.
- **Wrap-around.** Pointers wrap from `FIFO_DEPTH-1` to 0 with no gap.
- **Flag timing.** `almostFull` and `fifoCount` are registered and reflect the state after the last edge.
- **Reset mid-operation.** Reset discards the in-flight vector and all FIFO contents. The cycle after reset, `elementValid=0` even if `elementReady` was high.

## Test plan
1. **Single vector.**
   - Stimulus: pulse `vectorValid` one cycle with elements 0..5 = 0x00001..0x00006, `elementReady=1`.
   - Required response:
     - `elementValid` rises 1 cycle after the capture edge.
     - Output is 0x00001..0x00006 on 6 consecutive cycles, with `elementIndex` 0..5.
     - `lastElement` is high only on 0x00006.
     - Then `elementValid` returns to 0.
2. **Backpressure.**
   - Stimulus: same vector, `elementReady` toggling 1,0,0,1,…
   - Required response:
     - Each element holds stable while ready is 0.
     - All 6 elements are delivered in order.
     - `fifoCount` is 0 throughout after the pop.
3. **Back-to-back vectors.**
   - Stimulus: 3 vectors on consecutive cycles, `elementReady=1`.
   - Required response:
     - 18 elements on 18 consecutive cycles with no gap at vector boundaries.
     - `fifoCount` peaks at 2.
4. **Overflow.**
   - Stimulus: `elementReady=0`, then 6 vectors V0..V5 on consecutive cycles (`FIFO_DEPTH=4`).
   - Required response:
     - V0 is in the serializer and V1..V4 are stored.
     - V5 is dropped and `overflow`=1.
     - `almostFull` rises when `fifoCount` reaches 3.
     - After releasing ready, exactly V0..V4 are delivered in order.
5. **Full plus simultaneous pop.**
   - Stimulus: FIFO full, last element of the serializer vector handshaking on the same edge as a new `vectorValid`.
   - Required response:
     - The new vector is dropped and `overflow`=1.
     - `fifoCount` goes to 3.
6. **Reset mid-vector.**
   - Stimulus: assert `reset` for 1 cycle while `elementIndex`=3 and `fifoCount`=2.
   - Required response:
     - Next cycle: `elementValid`=0, `fifoCount`=0, `overflow`=0.
     - A new vector afterwards starts at `elementIndex`=0.

Source files
------------

// File: rtl/vector_output_unpacker.sv
// Buffers whole vectors from the CPU write-back port in a small FIFO and replays
// them one element per handshake, flagging vectors lost when the FIFO is full.
module vector_output_unpacker #(
    parameter int DATA_WIDTH  = 19,
    parameter int VECTOR_SIZE = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [VECTOR_SIZE*DATA_WIDTH-1:0]     vectorIn,
    input  logic                                  vectorValid,
    output logic [DATA_WIDTH-1:0]                 elementOut,
    output logic                                  elementValid,
    input  logic                                  elementReady,
    output logic [$clog2(VECTOR_SIZE)-1:0]        elementIndex,
    output logic                                  lastElement,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifoCount,
    output logic                                  almostFull,
    output logic                                  overflow
);
    localparam int VEC_W = VECTOR_SIZE * DATA_WIDTH;
    localparam int IDX_W = $clog2(VECTOR_SIZE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    function automatic logic [DATA_WIDTH-1:0] elem_sel(input logic [VEC_W-1:0] vec,
                                                       input logic [IDX_W-1:0] idx);
        elem_sel = '0;
        for (int k = 0; k < VECTOR_SIZE; k++) begin
            if (idx == IDX_W'(k)) elem_sel = vec[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endfunction

    state_t                 state_q, state_d;
    logic [VEC_W-1:0]       hold_q, hold_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VEC_W-1:0]       mem_q [FIFO_DEPTH];
    logic [VEC_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0]  elem_q, elem_d;
    logic                   valid_q, valid_d, last_q, last_d;
    logic                   af_q, af_d, ovf_q, ovf_d;
    logic                   wr_en_s, pop_s;

    // Serializer: pop a new vector when idle or right after the last element leaves.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (count_q != '0) begin
                    pop_s   = 1'b1;
                    hold_d  = mem_q[rd_ptr_q];
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (elementReady) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (count_q != '0) begin
                        pop_s  = 1'b1;
                        hold_d = mem_q[rd_ptr_q];
                        idx_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // FIFO storage, pointers, occupancy and sticky overflow; full check uses count_q.
    always_comb begin
        wr_en_s = vectorValid && (count_q < FULL_CNT);
        mem_d   = mem_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = vectorIn;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        af_d  = (count_d >= AF_CNT);
        ovf_d = ovf_q | (vectorValid & ~wr_en_s);
    end

    // Output stage, computed from next state so every output comes from a flop.
    always_comb begin
        valid_d = (state_d == ST_SEND);
        if (valid_d) begin
            elem_d = elem_sel(hold_d, idx_d);
            last_d = (idx_d == LAST_IDX);
        end else begin
            elem_d = '0;
            last_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            idx_q    <= '0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            elem_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            elem_q   <= elem_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign elementOut   = elem_q;
    assign elementValid = valid_q;
    assign elementIndex = idx_q;
    assign lastElement  = last_q;
    assign fifoCount    = count_q;
    assign almostFull   = af_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_vector_output_unpacker.sv
// Self-checking bench for vector_output_unpacker: a scoreboard of expected elements
// plus a table of vector writes with the expected FIFO flags after each one.
module tb_vector_output_unpacker;
    localparam int DW = 19;
    localparam int VS = 6;
    localparam int VW = DW * VS;

    logic          clock, reset, vectorValid, elementReady;
    logic [VW-1:0] vectorIn;
    logic [DW-1:0] elementOut;
    logic          elementValid, lastElement, almostFull, overflow;
    logic [2:0]    elementIndex;
    logic [2:0]    fifoCount;

    vector_output_unpacker dut (
        .clock(clock), .reset(reset), .vectorIn(vectorIn), .vectorValid(vectorValid),
        .elementOut(elementOut), .elementValid(elementValid), .elementReady(elementReady),
        .elementIndex(elementIndex), .lastElement(lastElement), .fifoCount(fifoCount),
        .almostFull(almostFull), .overflow(overflow)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [2:0]    idx;
        logic          last;
    } exp_t;

    typedef struct {
        logic [DW-1:0] base;
        logic          drop;
        int            cnt;
        logic          af;
        logic          ovf;
    } row_t;

    exp_t sb_q[$];
    row_t tbl[9];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [VW-1:0] make_vec(input logic [DW-1:0] base);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < VS; k++) v[k*DW +: DW] = base + DW'(k);
        return v;
    endfunction

    task automatic push_vec(input logic [VW-1:0] v);
        exp_t e;
        for (int k = 0; k < VS; k++) begin
            e.data = v[k*DW +: DW];
            e.idx  = 3'(k);
            e.last = (k == VS - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_vec(input logic [DW-1:0] base, input logic drop);
        vectorIn    = make_vec(base);
        vectorValid = 1'b1;
        if (!drop) push_vec(vectorIn);
        tick();
    endtask

    task automatic run_table(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            drive_vec(tbl[i].base, tbl[i].drop);
            check($sformatf("row%0d_count", i), fifoCount, tbl[i].cnt);
            check($sformatf("row%0d_almost_full", i), almostFull, tbl[i].af);
            check($sformatf("row%0d_overflow", i), overflow, tbl[i].ovf);
        end
        vectorValid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || elementValid) && n < 200) begin
            tick();
            n++;
        end
        check(name, (n < 200), 1'b1);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        vectorValid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb_q.delete();
    endtask

    // Monitor: checks every accepted element against the scoreboard and stall stability.
    initial begin
        logic prev_stall;
        exp_t prev_out, got, e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clock);
            got = {elementOut, elementIndex, lastElement};
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("stall_hold", {elementValid, got}, {1'b1, prev_out});
                if (elementValid && elementReady) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_elem: got %0h expected no element", got);
                    end else begin
                        e = sb_q.pop_front();
                        check("elem", got, e);
                    end
                end
                prev_stall = elementValid && !elementReady;
                prev_out   = got;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [3:0] pat;
        reset        = 1'b1;
        vectorValid  = 1'b0;
        vectorIn     = '0;
        elementReady = 1'b0;
        pat          = 4'b1001;

        tbl[0] = '{19'h00100, 1'b0, 1, 1'b0, 1'b0};
        tbl[1] = '{19'h00200, 1'b0, 1, 1'b0, 1'b0};
        tbl[2] = '{19'h00300, 1'b0, 2, 1'b0, 1'b0};
        tbl[3] = '{19'h01000, 1'b0, 1, 1'b0, 1'b0};
        tbl[4] = '{19'h02000, 1'b0, 1, 1'b0, 1'b0};
        tbl[5] = '{19'h03000, 1'b0, 2, 1'b0, 1'b0};
        tbl[6] = '{19'h04000, 1'b0, 3, 1'b1, 1'b0};
        tbl[7] = '{19'h05000, 1'b0, 4, 1'b1, 1'b0};
        tbl[8] = '{19'h06000, 1'b1, 4, 1'b1, 1'b1};

        do_reset();
        check("rst_valid", elementValid, 1'b0);
        check("rst_outputs", {elementOut, elementIndex, lastElement}, '0);
        check("rst_flags", {fifoCount, almostFull, overflow}, '0);

        // Single vector with ready held high
        elementReady = 1'b1;
        drive_vec(19'h00001, 1'b0);
        vectorValid = 1'b0;
        check("t1_valid_at_capture", elementValid, 1'b0);
        check("t1_count_at_capture", fifoCount, 3'd1);
        tick();
        for (int i = 0; i < VS; i++) begin
            check($sformatf("t1_valid_%0d", i), elementValid, 1'b1);
            check($sformatf("t1_index_%0d", i), elementIndex, i);
            tick();
        end
        check("t1_valid_after", elementValid, 1'b0);
        check("t1_drained", sb_q.size(), 0);

        // Backpressure with ready pattern 1,0,0,1
        elementReady = 1'b0;
        drive_vec(19'h00011, 1'b0);
        vectorValid = 1'b0;
        tick();
        n = 0;
        while (sb_q.size() > 0 && n < 40) begin
            elementReady = pat[3 - (n % 4)];
            check("t2_count_zero", fifoCount, 3'd0);
            tick();
            n++;
        end
        check("t2_completed", (n < 40), 1'b1);
        check("t2_valid_after", elementValid, 1'b0);

        // Back-to-back vectors: no bubbles across vector boundaries
        elementReady = 1'b1;
        run_table(0, 3);
        n = 0;
        while (elementValid && n < 40) begin
            n++;
            tick();
        end
        check("t3_continuous_cycles", n, 17);
        check("t3_drained", sb_q.size(), 0);

        // Overflow: V0 in serializer, V1..V4 stored, V5 dropped
        do_reset();
        elementReady = 1'b0;
        run_table(3, 6);
        elementReady = 1'b1;
        drain("t4_drain");
        check("t4_overflow_sticky", overflow, 1'b1);

        // Full FIFO with pop of last element on the same edge as a new write
        do_reset();
        elementReady = 1'b0;
        run_table(3, 5);
        elementReady = 1'b1;
        for (int i = 0; i < VS - 1; i++) tick();
        check("t5_index_before", {elementIndex, lastElement}, {3'd5, 1'b1});
        drive_vec(19'h07000, 1'b1);
        vectorValid = 1'b0;
        check("t5_count", fifoCount, 3'd3);
        check("t5_overflow", overflow, 1'b1);
        check("t5_next_vector", {elementValid, elementIndex}, {1'b1, 3'd0});
        drain("t5_drain");

        // Reset mid-vector with index 3 and two vectors queued
        elementReady = 1'b0;
        drive_vec(19'h00a00, 1'b0);
        drive_vec(19'h00b00, 1'b0);
        drive_vec(19'h00c00, 1'b0);
        vectorValid  = 1'b0;
        elementReady = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t6_pre_state", {elementIndex, fifoCount, overflow}, {3'd3, 3'd2, 1'b1});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        check("t6_after_reset", {elementValid, fifoCount, overflow, almostFull}, '0);
        tick();
        check("t6_idle_after_reset", elementValid, 1'b0);
        drive_vec(19'h00d00, 1'b0);
        vectorValid = 1'b0;
        tick();
        check("t6_restart", {elementValid, elementIndex, elementOut}, {1'b1, 3'd0, 19'h00d00});
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
